// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: sequences the 6502 reset, NMI and IRQ entry cycles.
// While busy is high this block owns the address bus, rw, data_out, the
// stack-pointer decrement strobe and the PC load port. NMI is edge-triggered
// and unmaskable; IRQ is level-sensitive and masked by the I flag. NMI
// arriving during an IRQ push phase hijacks the vector fetch.
module interrupt_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE   = 8'h01
) (
  input  logic        clk,
  input  logic        res,
  input  logic        rdy,
  input  logic        irq,
  input  logic        nmi,
  input  logic        instr_boundary,
  input  logic [6:0]  psr_in,
  input  logic [7:0]  sp_in,
  input  logic [15:0] pc_in,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [15:0] address,
  output logic        rw,
  output logic [7:0]  data_out,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_load_value,
  output logic        set_i_flag,
  output logic [1:0]  vector_id
);

  typedef enum logic [3:0] {
    S_RST_HOLD,
    S_RST_VL,
    S_RST_VH,
    S_IDLE,
    S_PUSH_PCH,
    S_PUSH_PCL,
    S_PUSH_P,
    S_VEC_L,
    S_VEC_H,
    S_LOAD_PC
  } state_t;

  localparam logic [1:0] VID_NONE  = 2'b00;
  localparam logic [1:0] VID_RESET = 2'b01;
  localparam logic [1:0] VID_NMI   = 2'b10;
  localparam logic [1:0] VID_IRQ   = 2'b11;

  state_t      state;
  logic [15:0] pc_saved;
  logic [7:0]  vec_lo;
  logic [7:0]  vec_hi;
  logic [1:0]  vid_q;
  logic        nmi_prev;
  logic        nmi_pending;

  logic        nmi_edge;
  logic        take;
  logic        nmi_clear;
  logic [15:0] vector_base;

  logic        rw_raw;
  logic        sp_dec_raw;
  logic        pc_load_raw;
  logic        set_i_raw;

  // The B bit of the live status register never reaches the stack image.
  logic        unused_b_flag;
  assign unused_b_flag = psr_in[4];

  assign nmi_edge    = nmi & ~nmi_prev;
  assign take        = instr_boundary & (nmi_pending | (irq & ~psr_in[2]));
  assign nmi_clear   = rdy & (state == S_PUSH_P) & nmi_pending;
  assign vector_base = (vid_q == VID_NMI) ? NMI_VECTOR : IRQ_VECTOR;

  // NMI edge detector; runs every cycle regardless of rdy so no edge is lost.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and simulation matches the synthesized netlist.
    nmi_prev <= nmi;
    if (res)
      nmi_pending <= 1'b0;
    else if (nmi_edge)
      nmi_pending <= 1'b1;   // a coincident edge beats the clear
    else if (nmi_clear)
      nmi_pending <= 1'b0;
  end

  // Sequencer state, captured vector bytes, saved PC and vector identity.
  always_ff @(posedge clk) begin
    if (res) begin
      state  <= S_RST_HOLD;
      vid_q  <= VID_NONE;
      vec_lo <= 8'h00;
      vec_hi <= 8'h00;
    end else if (rdy) begin
      case (state)
        S_RST_HOLD: begin
          state <= S_RST_VL;
          vid_q <= VID_RESET;
        end
        S_RST_VL: begin
          vec_lo <= data_in;
          state  <= S_RST_VH;
        end
        S_RST_VH: begin
          vec_hi <= data_in;
          state  <= S_LOAD_PC;
        end
        S_IDLE: begin
          if (take) begin
            // NOTE: pc_saved is pure datapath; it is always written before
            // being read, so it carries no reset.
            pc_saved <= pc_in;
            vid_q    <= nmi_pending ? VID_NMI : VID_IRQ;
            state    <= S_PUSH_PCH;
          end
        end
        S_PUSH_PCH: state <= S_PUSH_PCL;
        S_PUSH_PCL: state <= S_PUSH_P;
        S_PUSH_P: begin
          // Final vector choice: a pending NMI hijacks an IRQ sequence.
          vid_q <= nmi_pending ? VID_NMI : VID_IRQ;
          state <= S_VEC_L;
        end
        S_VEC_L: begin
          vec_lo <= data_in;
          state  <= S_VEC_H;
        end
        S_VEC_H: begin
          vec_hi <= data_in;
          state  <= S_LOAD_PC;
        end
        S_LOAD_PC: begin
          vid_q <= VID_NONE;
          state <= S_IDLE;
        end
        default: state <= S_RST_HOLD;
      endcase
    end
  end

  // Moore decode of bus and strobe outputs from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    busy          = 1'b1;
    address       = 16'h0000;
    rw_raw        = 1'b1;
    data_out      = 8'h00;
    sp_dec_raw    = 1'b0;
    pc_load_raw   = 1'b0;
    set_i_raw     = 1'b0;
    pc_load_value = 16'h0000;
    case (state)
      S_RST_HOLD: ;
      S_RST_VL:   address = RESET_VECTOR;
      S_RST_VH: begin
        address   = RESET_VECTOR + 16'd1;
        set_i_raw = 1'b1;
      end
      S_IDLE:     busy = 1'b0;
      S_PUSH_PCH: begin
        address    = {STACK_PAGE, sp_in};
        rw_raw     = 1'b0;
        sp_dec_raw = 1'b1;
        data_out   = pc_saved[15:8];
      end
      S_PUSH_PCL: begin
        address    = {STACK_PAGE, sp_in};
        rw_raw     = 1'b0;
        sp_dec_raw = 1'b1;
        data_out   = pc_saved[7:0];
      end
      S_PUSH_P: begin
        address    = {STACK_PAGE, sp_in};
        rw_raw     = 1'b0;
        sp_dec_raw = 1'b1;
        data_out   = {psr_in[6:5], 1'b1, 1'b0, psr_in[3:0]};
      end
      S_VEC_L: begin
        address   = vector_base;
        set_i_raw = 1'b1;
      end
      S_VEC_H:    address = vector_base + 16'd1;
      S_LOAD_PC: begin
        pc_load_raw   = 1'b1;
        pc_load_value = {vec_hi, vec_lo};
      end
      default: ;
    endcase
  end

  // A frozen cycle must not write, move the stack or touch PC / I flag.
  assign rw         = rw_raw | ~rdy;
  assign sp_dec     = sp_dec_raw & rdy;
  assign pc_load    = pc_load_raw & rdy;
  assign set_i_flag = set_i_raw & rdy;
  assign vector_id  = vid_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed scenarios against a cycle-list model of
// the reset / interrupt entry bus sequences, plus literal spot checks.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        res, rdy, irq, nmi, instr_boundary;
  logic [6:0]  psr;
  logic [7:0]  sp = 8'hFF;
  logic [15:0] pc;
  logic [7:0]  data_in;
  logic        busy, rw, sp_dec, pc_load, set_i_flag;
  logic [15:0] address, pc_load_value;
  logic [7:0]  data_out;
  logic [1:0]  vector_id;

  interrupt_sequencer dut (
    .clk            (clk),
    .res            (res),
    .rdy            (rdy),
    .irq            (irq),
    .nmi            (nmi),
    .instr_boundary (instr_boundary),
    .psr_in         (psr),
    .sp_in          (sp),
    .pc_in          (pc),
    .data_in        (data_in),
    .busy           (busy),
    .address        (address),
    .rw             (rw),
    .data_out       (data_out),
    .sp_dec         (sp_dec),
    .pc_load        (pc_load),
    .pc_load_value  (pc_load_value),
    .set_i_flag     (set_i_flag),
    .vector_id      (vector_id)
  );

  always #5 clk = ~clk;

  // Memory image: vectors reset=1234, NMI=ABCD, IRQ=5678.
  function automatic logic [7:0] rd(input logic [15:0] a);
    case (a)
      16'hFFFA: rd = 8'hCD;
      16'hFFFB: rd = 8'hAB;
      16'hFFFC: rd = 8'h34;
      16'hFFFD: rd = 8'h12;
      16'hFFFE: rd = 8'h78;
      16'hFFFF: rd = 8'h56;
      default:  rd = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always_comb data_in = rd(address);

  // Stack pointer owned by the surrounding CPU.
  always @(posedge clk) if (sp_dec) sp <= sp - 8'd1;

  typedef struct packed {
    logic        busy, rw, sp_dec, pc_load, set_i;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [15:0] pcv;
    logic [1:0]  vid;
    logic        chk_addr, chk_dout, chk_pcv;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] wr_log[$];
  int          passes = 0, total = 0, cyc = 0;
  int          set_i_cnt = 0, pc_load_cnt = 0, busy_cnt = 0;
  logic [15:0] last_pcv = 16'h0000;
  logic        chk_en = 1'b0;
  logic [7:0]  m_sp = 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passes++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset: one hold cycle, vector low/high reads, PC load.
  task automatic model_reset();
    exp_t e;
    e = '0; e.busy = 1; e.rw = 1; e.chk_addr = 1; e.chk_dout = 1; e.chk_pcv = 1;
    exp_q.push_back(e);
    e = '0; e.busy = 1; e.rw = 1; e.vid = 2'b01; e.chk_addr = 1; e.addr = 16'hFFFC;
    exp_q.push_back(e);
    e.addr = 16'hFFFD; e.set_i = 1;
    exp_q.push_back(e);
    e = '0; e.busy = 1; e.rw = 1; e.vid = 2'b01; e.pc_load = 1; e.chk_pcv = 1;
    e.pcv = {rd(16'hFFFD), rd(16'hFFFC)};
    exp_q.push_back(e);
  endtask

  // Interrupt entry: three pushes, two vector reads, PC load. The first
  // ncyc cycles are queued; stall_pcl frozen copies precede the PCL push.
  task automatic model_int(input logic [15:0] pc_v, input logic [6:0] p,
                           input bit first_nmi, input bit final_nmi,
                           input int stall_pcl, input int ncyc);
    exp_t        e[6];
    exp_t        st;
    logic [15:0] vec;
    vec = final_nmi ? 16'hFFFA : 16'hFFFE;
    for (int k = 0; k < 6; k++) begin
      e[k] = '0; e[k].busy = 1; e[k].rw = 1; e[k].chk_addr = 1;
      e[k].vid = (k < 3) ? (first_nmi ? 2'b10 : 2'b11) : (final_nmi ? 2'b10 : 2'b11);
    end
    for (int k = 0; k < 3; k++) begin
      e[k].rw = 0; e[k].sp_dec = 1; e[k].chk_dout = 1;
      e[k].addr = {8'h01, m_sp - 8'(k)};
    end
    e[0].dout = pc_v[15:8];
    e[1].dout = pc_v[7:0];
    e[2].dout = {p[6:5], 2'b10, p[3:0]};
    e[3].addr = vec; e[3].set_i = 1;
    e[4].addr = vec + 16'd1;
    e[5].chk_addr = 0; e[5].pc_load = 1; e[5].chk_pcv = 1;
    e[5].pcv = {rd(vec + 16'd1), rd(vec)};
    for (int k = 0; k < ncyc; k++) begin
      if (k == 1)
        for (int s = 0; s < stall_pcl; s++) begin
          st = e[1]; st.rw = 1; st.sp_dec = 0;
          exp_q.push_back(st);
        end
      exp_q.push_back(e[k]);
    end
    if (ncyc >= 3) m_sp = m_sp - 8'd3;
  endtask

  // Per-cycle comparison against the model; an empty queue means idle.
  always @(negedge clk) begin : compare
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin e = '0; e.rw = 1'b1; end
      cyc++;
      check("busy", busy, e.busy);
      check("rw", rw, e.rw);
      check("sp_dec", sp_dec, e.sp_dec);
      check("pc_load", pc_load, e.pc_load);
      check("set_i_flag", set_i_flag, e.set_i);
      check("vector_id", vector_id, e.vid);
      if (e.chk_addr) check("address", address, e.addr);
      if (e.chk_dout) check("data_out", data_out, e.dout);
      if (e.chk_pcv)  check("pc_load_value", pc_load_value, e.pcv);
      if (!rw) wr_log.push_back({address, data_out});
      if (set_i_flag) set_i_cnt++;
      if (pc_load) begin pc_load_cnt++; last_pcv = pc_load_value; end
      if (busy) busy_cnt++;
    end
  end

  initial begin
    int wb, pb, bb, sb;
    res = 1; rdy = 1; irq = 0; nmi = 0; instr_boundary = 0; psr = 7'h00; pc = 16'h0000;
    tick(2);

    // Reset release: reads FFFC/FFFD, loads 1234 on the third cycle.
    chk_en = 1; res = 0; sb = set_i_cnt; pb = pc_load_cnt;
    model_reset();
    tick(3);
    check("rst_pc_load_lit", pc_load, 1);
    check("rst_pcv_lit", pc_load_value, 16'h1234);
    tick(1);
    check("rst_release_busy_lit", busy, 0);
    check("rst_set_i_once", set_i_cnt - sb, 1);
    check("rst_pc_load_once", pc_load_cnt - pb, 1);
    check("rst_no_writes", wr_log.size(), 0);

    // IRQ taken with I clear.
    psr = 7'b1000001; pc = 16'h0456; irq = 1; instr_boundary = 1;
    tick(1);
    instr_boundary = 0; irq = 0; wb = wr_log.size();
    model_int(pc, psr, 0, 0, 0, 6);
    tick(6);
    check("irq_wr0_lit", wr_log[wb],     {16'h01FF, 8'h04});
    check("irq_wr1_lit", wr_log[wb + 1], {16'h01FE, 8'h56});
    check("irq_wr2_lit", wr_log[wb + 2], {16'h01FD, 8'hA1});
    check("irq_sp_lit", sp, 8'hFC);
    check("irq_vector_lit", last_pcv, 16'h5678);

    // Masked IRQ: nothing happens.
    psr = 7'b0000100; irq = 1; instr_boundary = 1; pb = pc_load_cnt; wb = wr_log.size();
    tick(1);
    instr_boundary = 0;
    tick(3);
    irq = 0;
    check("masked_no_load", pc_load_cnt - pb, 0);
    check("masked_no_write", wr_log.size() - wb, 0);

    // NMI edge during PUSH_PCL hijacks the IRQ vector fetch.
    psr = 7'h00; pc = 16'h1357; irq = 1; instr_boundary = 1;
    tick(1);
    instr_boundary = 0; irq = 0;
    model_int(pc, psr, 0, 1, 0, 6);
    tick(1);
    nmi = 1;
    tick(5);
    check("hijack_vector_lit", last_pcv, 16'hABCD);
    pb = pc_load_cnt; instr_boundary = 1;
    tick(1);
    instr_boundary = 0;
    tick(3);
    check("nmi_held_no_reservice", pc_load_cnt - pb, 0);
    nmi = 0;

    // rdy low for three cycles in PUSH_PCL stretches the sequence by three.
    psr = 7'b0100010; pc = 16'h2468; irq = 1; instr_boundary = 1;
    tick(1);
    instr_boundary = 0; irq = 0; bb = busy_cnt;
    model_int(pc, psr, 0, 0, 3, 6);
    tick(1);
    rdy = 0;
    tick(3);
    rdy = 1;
    tick(5);
    check("stall_busy_cycles_lit", busy_cnt - bb, 9);

    // Reset during VEC_H aborts without loading PC, then refetches reset vector.
    psr = 7'h00; pc = 16'h0ACE; irq = 1; instr_boundary = 1;
    tick(1);
    instr_boundary = 0; irq = 0; pb = pc_load_cnt;
    model_int(pc, psr, 0, 0, 0, 5);
    model_reset();
    tick(4);
    res = 1;
    tick(1);
    res = 0;
    check("abort_hold_busy_lit", busy, 1);
    tick(4);
    check("abort_single_load", pc_load_cnt - pb, 1);
    check("abort_reset_vector_lit", last_pcv, 16'h1234);

    // NMI edge after the selection point stays pending for the next boundary.
    pc = 16'h3000; irq = 1; instr_boundary = 1;
    tick(1);
    instr_boundary = 0; irq = 0;
    model_int(pc, psr, 0, 0, 0, 6);
    tick(3);
    nmi = 1;
    tick(3);
    check("late_nmi_irq_vector_lit", last_pcv, 16'h5678);
    instr_boundary = 1;
    tick(1);
    instr_boundary = 0;
    model_int(pc, psr, 1, 1, 0, 6);
    tick(6);
    check("late_nmi_serviced_lit", last_pcv, 16'hABCD);
    nmi = 0;

    tick(2);
    check("model_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
